// File: rtl/sram_scan_burst_ctrl.sv
// Serial-scan SRAM burst controller.
// A scanned command frame (op, count, addr) selects one of four bursts against a
// single-port SRAM: WRITE, READ, FILL or COMPARE. Read data returns on scan_out.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for the first scan_en=1 bit of a command frame
// S_CMD      | shifting the remaining command frame bits
// S_PAT      | shifting the FILL pattern / COMPARE expected word
// S_WDATA    | shifting one WRITE data word
// S_WR       | one SRAM write cycle (FILL stays here for count+1 cycles)
// S_RD_ISSUE | one SRAM read access cycle
// S_RD_WAIT  | RD_LAT cycles of read latency, captures mem_dout on the last
// S_RD_SHIFT | drives the captured word on scan_out, LSB first
// S_CMP      | compares the captured word against the expected word
// S_DONE     | one-cycle completion pulse
module sram_scan_burst_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk_1,
  input  logic              rst_n_sync,
  input  logic              scan_in,
  input  logic              scan_en,
  output logic              scan_out,
  output logic              scan_out_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W:0]    err_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CMD_W = 2 + CNT_W + ADDR_W;
  localparam int BIT_W = $clog2(CMD_W + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CMP   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_PAT, S_WDATA, S_WR,
    S_RD_ISSUE, S_RD_WAIT, S_RD_SHIFT, S_CMP, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CMD_W-1:0]   r_cmd;
  logic [BIT_W-1:0]   r_bit;
  logic [LAT_W-1:0]   r_lat;
  logic [CNT_W-1:0]   r_words;
  logic [DATA_W-1:0]  r_word;
  logic [DATA_W-1:0]  r_rd;
  logic               r_first;
  logic [CNT_W:0]     r_err;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_din;

  logic [CMD_W-1:0]   w_cmd_nxt;
  logic [DATA_W-1:0]  w_word_nxt;
  logic [1:0]         w_op;
  logic [1:0]         w_op_nxt;
  logic [ADDR_W-1:0]  w_base;
  logic               w_bit_last;
  logic               w_lat_last;
  logic               w_words_last;
  logic               w_cmd_last;
  logic               w_acc;

  assign w_cmd_nxt    = {scan_in, r_cmd[CMD_W-1:1]};
  assign w_word_nxt   = {scan_in, r_word[DATA_W-1:1]};
  assign w_op         = r_cmd[1:0];
  assign w_op_nxt     = w_cmd_nxt[1:0];
  assign w_bit_last   = (r_bit == BIT_W'(1));
  assign w_lat_last   = (r_lat == LAT_W'(1));
  assign w_words_last = (r_words == '0);
  assign w_cmd_last   = (r_state == S_CMD) && scan_en && w_bit_last;
  // A READ goes straight from CMD to RD_ISSUE, before r_cmd holds the full frame.
  assign w_base       = (r_state == S_CMD) ? w_cmd_nxt[CMD_W-1 -: ADDR_W]
                                           : r_cmd[CMD_W-1 -: ADDR_W];
  assign w_acc        = (w_state_nxt == S_WR) || (w_state_nxt == S_RD_ISSUE);

  // State register
  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (scan_en) w_state_nxt = S_CMD;
      S_CMD:      if (scan_en && w_bit_last) begin
                    case (w_op_nxt)
                      OP_WRITE: w_state_nxt = S_WDATA;
                      OP_READ:  w_state_nxt = S_RD_ISSUE;
                      default:  w_state_nxt = S_PAT;
                    endcase
                  end
      S_PAT:      if (scan_en && w_bit_last)
                    w_state_nxt = (w_op == OP_FILL) ? S_WR : S_RD_ISSUE;
      S_WDATA:    if (scan_en && w_bit_last) w_state_nxt = S_WR;
      S_WR:       if (w_words_last)           w_state_nxt = S_DONE;
                  else if (w_op == OP_WRITE)  w_state_nxt = S_WDATA;
                  else                        w_state_nxt = S_WR;
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (w_lat_last)
                    w_state_nxt = (w_op == OP_READ) ? S_RD_SHIFT : S_CMP;
      S_RD_SHIFT: if (w_bit_last)
                    w_state_nxt = w_words_last ? S_DONE : S_RD_ISSUE;
      S_CMP:      w_state_nxt = w_words_last ? S_DONE : S_RD_ISSUE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Shift registers, down-counters, SRAM port registers and error count
  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_cmd      <= '0;
      r_bit      <= '0;
      r_lat      <= '0;
      r_words    <= '0;
      r_word     <= '0;
      r_rd       <= '0;
      r_first    <= 1'b0;
      r_err      <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      if (scan_en && (r_state == S_IDLE || r_state == S_CMD))
        r_cmd <= w_cmd_nxt;
      if (scan_en && (r_state == S_PAT || r_state == S_WDATA))
        r_word <= w_word_nxt;

      case (r_state)
        S_IDLE:                 if (scan_en) r_bit <= BIT_W'(CMD_W - 1);
        S_CMD, S_PAT, S_WDATA:  if (scan_en) r_bit <= w_bit_last ? BIT_W'(DATA_W) : r_bit - 1'b1;
        S_WR, S_RD_WAIT:        r_bit <= BIT_W'(DATA_W);
        S_RD_SHIFT:             r_bit <= r_bit - 1'b1;
        default:                r_bit <= r_bit;
      endcase

      if (r_state == S_RD_ISSUE)      r_lat <= LAT_W'(RD_LAT);
      else if (r_state == S_RD_WAIT)  r_lat <= r_lat - 1'b1;

      if (r_state == S_RD_WAIT && w_lat_last) r_rd <= mem_dout;
      else if (r_state == S_RD_SHIFT)         r_rd <= r_rd >> 1;

      if (w_cmd_last)
        r_words <= w_cmd_nxt[2 +: CNT_W];
      else if (!w_words_last && (r_state == S_WR || r_state == S_CMP ||
                                 (r_state == S_RD_SHIFT && w_bit_last)))
        r_words <= r_words - 1'b1;

      // The first access of a burst uses the frame address; later ones increment.
      if (r_state == S_IDLE) r_first <= 1'b1;
      else if (w_acc)        r_first <= 1'b0;

      if (w_acc)
        r_mem_addr <= r_first ? w_base : r_mem_addr + 1'b1;
      if (w_state_nxt == S_WR && r_state != S_WR)
        r_mem_din <= w_word_nxt;

      if (w_cmd_last && w_op_nxt == OP_CMP)
        r_err <= '0;
      else if (r_state == S_CMP && r_rd != r_word)
        r_err <= r_err + 1'b1;
    end
  end

  assign mem_en         = (r_state == S_WR) || (r_state == S_RD_ISSUE);
  assign mem_we         = (r_state == S_WR);
  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;
  assign scan_out       = (r_state == S_RD_SHIFT) && r_rd[0];
  assign scan_out_valid = (r_state == S_RD_SHIFT);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign err_cnt        = r_err;

endmodule

// File: tb/tb_sram_scan_burst_ctrl.sv
// Bench for sram_scan_burst_ctrl: SRAM model with RD_LAT=1, scoreboard queues for
// expected SRAM writes and expected scan_out words.
module tb_sram_scan_burst_ctrl;

  logic        clk_1 = 1'b0;
  logic        rst_n_sync = 1'b0;
  logic        scan_in = 1'b0;
  logic        scan_en = 1'b0;
  logic        scan_out, scan_out_valid, busy, done;
  logic [12:0] err_cnt;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;

  sram_scan_burst_ctrl #(.ADDR_W(12), .DATA_W(8), .CNT_W(12), .RD_LAT(1)) dut (
    .clk_1(clk_1), .rst_n_sync(rst_n_sync), .scan_in(scan_in), .scan_en(scan_en),
    .scan_out(scan_out), .scan_out_valid(scan_out_valid), .busy(busy), .done(done),
    .err_cnt(err_cnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk_1 = ~clk_1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  mem [0:4095];
  logic [19:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  int wr_cnt = 0, wr_first = 0, wr_last = 0;
  int vcnt = 0, rd_bytes = 0, en_cnt = 0, bitn = 0;
  logic [7:0] rbyte = 8'h00;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter
  always @(posedge clk_1) cyc <= cyc + 1;

  // Single-port SRAM model, read latency 1
  always @(posedge clk_1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  // Output monitor: checks writes and scanned-out words against the queues
  always @(negedge clk_1) begin
    if (!rst_n_sync) begin
      bitn = 0;
    end else begin
      if (mem_en) en_cnt++;
      if (mem_en && mem_we) begin
        wr_cnt++;
        if (wr_cnt == 1) wr_first = cyc;
        wr_last = cyc;
        if (exp_wr.size() == 0) chk_eq("wr_unexpected_qsize", exp_wr.size(), 1);
        else chk_eq("wr_addr_data", {mem_addr, mem_din}, exp_wr.pop_front());
      end
      if (scan_out_valid) begin
        rbyte[bitn] = scan_out;
        bitn++;
        vcnt++;
        if (bitn == 8) begin
          bitn = 0;
          rd_bytes++;
          if (exp_rd.size() == 0) chk_eq("rd_unexpected_qsize", exp_rd.size(), 1);
          else chk_eq("rd_word", rbyte, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    @(posedge clk_1); #1;
  endtask

  task automatic idle_cycle();
    scan_en = 1'b0;
    scan_in = 1'b0;
    @(posedge clk_1); #1;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [11:0] cnt,
                            input logic [11:0] addr, input int pause_at, input int pause_len);
    logic [25:0] f;
    f = {addr, cnt, op};
    for (int i = 0; i < 26; i++) begin
      if (i == pause_at) repeat (pause_len) idle_cycle();
      drive_bit(f[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive_bit(w[i]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic got;
    scan_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk_eq({tag, "_done"}, got, 1);
    @(negedge clk_1);
    chk_eq({tag, "_busy_low"}, busy, 0);
    @(posedge clk_1); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int t0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    repeat (3) @(posedge clk_1);
    #1 rst_n_sync = 1'b1;
    @(negedge clk_1);
    chk_eq("rst_ctrl", {scan_out, scan_out_valid, busy, done, mem_en, mem_we}, 0);
    chk_eq("rst_addr_din", {mem_addr, mem_din}, 0);
    chk_eq("rst_err", err_cnt, 0);
    @(posedge clk_1); #1;

    // WRITE three words at 0x010
    wr_cnt = 0;
    exp_wr.push_back({12'h010, 8'hA5});
    exp_wr.push_back({12'h011, 8'h3C});
    exp_wr.push_back({12'h012, 8'hFF});
    send_frame(2'b00, 12'd2, 12'h010, -1, 0);
    chk_eq("wr_busy_during", busy, 1);
    send_word(8'hA5); idle_cycle();
    send_word(8'h3C); idle_cycle();
    send_word(8'hFF); idle_cycle();
    wait_done("write", 20);
    chk_eq("write_count", wr_cnt, 3);
    chk_eq("write_q_empty", exp_wr.size(), 0);

    // READ one word from 0x010
    vcnt = 0;
    exp_rd.push_back(8'hA5);
    send_frame(2'b01, 12'd0, 12'h010, -1, 0);
    wait_done("read", 40);
    chk_eq("read_valid_bits", vcnt, 8);
    chk_eq("read_q_empty", exp_rd.size(), 0);

    // FILL with wrap from 0xFFF to 0x000
    wr_cnt = 0;
    exp_wr.push_back({12'hFFE, 8'h55});
    exp_wr.push_back({12'hFFF, 8'h55});
    exp_wr.push_back({12'h000, 8'h55});
    exp_wr.push_back({12'h001, 8'h55});
    send_frame(2'b10, 12'd3, 12'hFFE, -1, 0);
    send_word(8'h55);
    wait_done("fill", 20);
    chk_eq("fill_count", wr_cnt, 4);
    chk_eq("fill_back_to_back", wr_last - wr_first, 3);
    chk_eq("fill_q_empty", exp_wr.size(), 0);

    // COMPARE with one bad word, then a clean one
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    mem[3] = 8'h01;
    wr_cnt = 0;
    send_frame(2'b11, 12'd7, 12'h000, -1, 0);
    send_word(8'h00);
    wait_done("cmp1", 60);
    chk_eq("cmp1_err_cnt", err_cnt, 1);
    mem[3] = 8'h00;
    send_frame(2'b11, 12'd7, 12'h000, -1, 0);
    send_word(8'h00);
    wait_done("cmp2", 60);
    chk_eq("cmp2_err_cnt", err_cnt, 0);
    chk_eq("cmp_no_writes", wr_cnt, 0);

    // Paused frame: same write, 5 cycles later
    exp_wr.push_back({12'h100, 8'h5A});
    t0 = cyc;
    send_frame(2'b00, 12'd0, 12'h100, -1, 0);
    send_word(8'h5A); idle_cycle();
    wait_done("nopause", 20);
    chk_eq("nopause_latency", wr_last - t0, 34);
    exp_wr.push_back({12'h100, 8'h5A});
    t0 = cyc;
    send_frame(2'b00, 12'd0, 12'h100, 10, 5);
    send_word(8'h5A); idle_cycle();
    wait_done("pause", 20);
    chk_eq("pause_latency", wr_last - t0, 39);

    // Reset during the 2nd word of a 5-word READ
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hFF);
    exp_rd.push_back(8'h00);
    exp_rd.push_back(8'h00);
    rd_bytes = 0;
    send_frame(2'b01, 12'd4, 12'h010, -1, 0);
    scan_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_1);
      if (rd_bytes == 1 && mem_en) begin
        got = 1'b1;
        break;
      end
    end
    chk_eq("rst_reach_word2", got, 1);
    repeat (3) @(posedge clk_1);
    #2 rst_n_sync = 1'b0;
    #1;
    chk_eq("midrst_ctrl", {scan_out, scan_out_valid, busy, done, mem_en, mem_we}, 0);
    chk_eq("midrst_addr_din", {mem_addr, mem_din}, 0);
    chk_eq("midrst_err", err_cnt, 0);
    exp_rd.delete();
    repeat (3) @(posedge clk_1);
    #1 rst_n_sync = 1'b1;
    en_cnt = 0;
    repeat (20) @(posedge clk_1);
    #1;
    chk_eq("post_rst_no_mem_en", en_cnt, 0);
    chk_eq("post_rst_idle", busy, 0);

    // WRITE after reset
    wr_cnt = 0;
    exp_wr.push_back({12'h020, 8'h11});
    exp_wr.push_back({12'h021, 8'h22});
    send_frame(2'b00, 12'd1, 12'h020, -1, 0);
    send_word(8'h11); idle_cycle();
    send_word(8'h22); idle_cycle();
    wait_done("post_rst_write", 20);
    chk_eq("post_rst_write_count", wr_cnt, 2);
    chk_eq("final_wr_q_empty", exp_wr.size(), 0);
    chk_eq("final_mem_021", mem[12'h021], 8'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
